fifo_ctrl: RTL and testbench

- Control end of the 8-entry, 10-bit dual-port memory. Turns a push/pop handshake into the memory's write/read strobes and ptr_write/ptr_read pointers.
- Tracks occupancy and raises full/empty/almost flags.
- Flags overflow and underflow errors, and marks when memory read data is valid.
- Sits between the upstream producer/consumer logic and the memory block.

---
 rtl/fifo_ctrl.sv | 85 ++++++++
 tb/tb_fifo_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer/count control for an 8x10 dual-port FIFO memory; FIFO_CTRL_ERR_STICKY_EN makes error sticky
module fifo_ctrl #(
    parameter int BITNUMBER       = 10,
    parameter int LENGTH          = 8,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [BITNUMBER-1:0]  data_in,
    output logic                  write,
    output logic                  read,
    output logic [ADDR_WIDTH-1:0] ptr_write,
    output logic [ADDR_WIDTH-1:0] ptr_read,
    output logic [BITNUMBER-1:0]  mem_data_in,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] LEN_C = (ADDR_WIDTH+1)'(LENGTH);
    localparam logic [ADDR_WIDTH:0] AF_C  = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_C  = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

    logic                push_ok;
    logic                pop_ok;
    logic                overflow;
    logic                underflow;
    logic [ADDR_WIDTH:0] count_next;

    // Strobes are suppressed while reset is held so the memory never sees a write during reset.
    assign push_ok     = push & ~full & ~reset;
    assign pop_ok      = pop & ~empty & ~reset;
    assign write       = push_ok;
    assign read        = pop_ok;
    assign mem_data_in = data_in;
    assign overflow    = push & full;
    assign underflow   = pop & empty;

    always_comb begin
        count_next = fifo_count;
        if (push_ok && !pop_ok)
            count_next = fifo_count + 1'b1;
        else if (pop_ok && !push_ok)
            count_next = fifo_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_write    <= '0;
            ptr_read     <= '0;
            fifo_count   <= '0;
            valid_out    <= 1'b0;
            error        <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (push_ok)
                ptr_write <= ptr_write + ADDR_WIDTH'(1);
            if (pop_ok)
                ptr_read <= ptr_read + ADDR_WIDTH'(1);
            fifo_count   <= count_next;
            valid_out    <= pop_ok;
            full         <= (count_next == LEN_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
`ifdef FIFO_CTRL_ERR_STICKY_EN
            error <= error | overflow | underflow;
`else
            error <= overflow | underflow;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl with a behavioural 8x10 memory
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset, push, pop;
    logic [9:0] data_in;
    logic       write, read, valid_out, full, empty, almost_full, almost_empty, error;
    logic [2:0] ptr_write, ptr_read;
    logic [9:0] mem_data_in;
    logic [3:0] fifo_count;

    logic [9:0] mem [8];
    logic [9:0] mem_dout;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_q [$];

    fifo_ctrl dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
        .write(write), .read(read), .ptr_write(ptr_write), .ptr_read(ptr_read),
        .mem_data_in(mem_data_in), .valid_out(valid_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .fifo_count(fifo_count), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write) mem[ptr_write] <= mem_data_in;
        if (read)  mem_dout <= mem[ptr_read];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic q, input logic [9:0] d);
        push = p;
        pop = q;
        data_in = d;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(1'b0, 1'b0, 10'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        push = 1'b1;
        pop = 1'b1;
        data_in = 10'h3ff;
        tick();
        #1;
        check("rst_write", 32'(write), 32'd0);
        check("rst_read", 32'(read), 32'd0);
        tick();
        check("rst_ptr_write", 32'(ptr_write), 32'd0);
        check("rst_ptr_read", 32'(ptr_read), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        reset = 1'b0;

        // Fill with 1..8
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 10'(i + 1));
            check("fill_write", 32'(write), 32'd1);
            check("fill_ptr_write", 32'(ptr_write), 32'(i));
            tick();
            check("fill_count", 32'(fifo_count), 32'(i + 1));
            check("fill_almost_full", 32'(almost_full), 32'(i + 1 >= 6));
            check("fill_full", 32'(full), 32'(i == 7));
            check("fill_empty", 32'(empty), 32'd0);
        end
        check("fill_ptr_wrap", 32'(ptr_write), 32'd0);
        drive(1'b1, 1'b0, 10'h155);
        check("ovf_write", 32'(write), 32'd0);
        tick();
        check("ovf_count", 32'(fifo_count), 32'd8);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_ptr_write", 32'(ptr_write), 32'd0);

        // Drain, expecting 1..8 back
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 10'd0);
            check("drain_read", 32'(read), 32'd1);
            check("drain_ptr_read", 32'(ptr_read), 32'(i));
            tick();
            check("drain_valid", 32'(valid_out), 32'd1);
            check("drain_data", 32'(mem_dout), 32'(i + 1));
            check("drain_count", 32'(fifo_count), 32'(7 - i));
            check("drain_empty", 32'(empty), 32'(i == 7));
            check("drain_almost_empty", 32'(almost_empty), 32'(7 - i <= 2));
            check("drain_full", 32'(full), 32'd0);
        end
        drive(1'b0, 1'b1, 10'd0);
        check("udf_read", 32'(read), 32'd0);
        tick();
        check("udf_error", 32'(error), 32'd1);
        check("udf_valid", 32'(valid_out), 32'd0);
        check("udf_count", 32'(fifo_count), 32'd0);
        check("udf_ptr_read", 32'(ptr_read), 32'd0);

        // Streaming: preload 3, then 10 simultaneous push/pop
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 10'(100 + i));
            exp_q.push_back(100 + i);
            tick();
        end
        check("stream_preload", 32'(fifo_count), 32'd3);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 10'(103 + i));
            exp_q.push_back(103 + i);
            check("stream_write", 32'(write), 32'd1);
            check("stream_read", 32'(read), 32'd1);
            tick();
            check("stream_valid", 32'(valid_out), 32'd1);
            check("stream_data", 32'(mem_dout), 32'(exp_q.pop_front()));
            check("stream_count", 32'(fifo_count), 32'd3);
        end
        check("stream_ptr_write", 32'(ptr_write), 32'd5);
        check("stream_ptr_read", 32'(ptr_read), 32'd2);

        // Empty with push and pop together
        do_reset();
        drive(1'b1, 1'b1, 10'h2aa);
        check("bnd_empty_write", 32'(write), 32'd1);
        check("bnd_empty_read", 32'(read), 32'd0);
        tick();
        check("bnd_empty_count", 32'(fifo_count), 32'd1);
        check("bnd_empty_error", 32'(error), 32'd1);
        check("bnd_empty_valid", 32'(valid_out), 32'd0);

        // Full with push and pop together
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 10'(20 + i));
            tick();
        end
        check("bnd_full_pre", 32'(full), 32'd1);
        drive(1'b1, 1'b1, 10'h3c3);
        check("bnd_full_write", 32'(write), 32'd0);
        check("bnd_full_read", 32'(read), 32'd1);
        tick();
        check("bnd_full_count", 32'(fifo_count), 32'd7);
        check("bnd_full_error", 32'(error), 32'd1);
        check("bnd_full_valid", 32'(valid_out), 32'd1);
        check("bnd_full_data", 32'(mem_dout), 32'd20);
        check("bnd_full_flag", 32'(full), 32'd0);

        // Error persistence over 5 legal idle cycles
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 10'd0);
            tick();
`ifdef FIFO_CTRL_ERR_STICKY_EN
            check("err_sticky", 32'(error), 32'd1);
`else
            check("err_pulse", 32'(error), 32'd0);
`endif
        end
        do_reset();
        check("err_after_reset", 32'(error), 32'd0);
        check("count_after_reset", 32'(fifo_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
